// File: rtl/ex_mem_stage_pipe.sv
// EX->MEM pipeline register with a 2-entry skid buffer. Latency is 1 cycle from accept to Out_Valid.
// In_Ready is registered as !skid_vld, so the EX stage never sees a combinational path from Out_Ready.
module ex_mem_stage_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int INSTR_WIDTH    = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Flush,
  input  logic                      In_Valid,
  output logic                      In_Ready,
  input  logic                      RegWrite_EX,
  input  logic                      MemtoReg_EX,
  input  logic                      Branch_EX,
  input  logic                      MemRead_EX,
  input  logic                      MemWrite_EX,
  input  logic                      Zero_EX,
  input  logic [DATA_WIDTH-1:0]     ALU_Result_EX,
  input  logic [DATA_WIDTH-1:0]     Read_Data_2_EX,
  input  logic [REG_ADDR_WIDTH-1:0] Write_Register_EX,
  input  logic [INSTR_WIDTH-1:0]    Instruction_EX,
  output logic                      Out_Valid,
  input  logic                      Out_Ready,
  output logic                      RegWrite_MEM,
  output logic                      MemtoReg_MEM,
  output logic                      Branch_MEM,
  output logic                      MemRead_MEM,
  output logic                      MemWrite_MEM,
  output logic                      Zero_MEM,
  output logic [DATA_WIDTH-1:0]     ALU_Result_MEM,
  output logic [DATA_WIDTH-1:0]     Write_Data_MEM,
  output logic [REG_ADDR_WIDTH-1:0] Write_Register_MEM,
  output logic [INSTR_WIDTH-1:0]    Instruction_MEM,
  output logic [CNT_WIDTH-1:0]      Stall_Count
);

  typedef struct packed {
    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      branch;
    logic                      mem_read;
    logic                      mem_write;
    logic                      zero;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
    logic [INSTR_WIDTH-1:0]    instr;
  } payload_t;

  payload_t               in_dat;
  payload_t               main_dat;
  payload_t               skid_dat;
  logic                   main_vld;
  logic                   skid_vld;
  logic                   accept;
  logic                   pop;
  logic [CNT_WIDTH-1:0]   stall_cnt;

  assign in_dat = '{
    reg_write:  RegWrite_EX,
    mem_to_reg: MemtoReg_EX,
    branch:     Branch_EX,
    mem_read:   MemRead_EX,
    mem_write:  MemWrite_EX,
    zero:       Zero_EX,
    alu_result: ALU_Result_EX,
    write_data: Read_Data_2_EX,
    write_reg:  Write_Register_EX,
    instr:      Instruction_EX
  };

  assign In_Ready  = ~skid_vld;
  assign Out_Valid = main_vld;
  assign accept    = In_Valid & ~skid_vld & ~Flush;
  assign pop       = main_vld & Out_Ready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_dat  <= '0;
      skid_dat  <= '0;
      stall_cnt <= '0;
    end else begin
      // Counts stalls even on a flush edge; saturates rather than wrapping
      if (main_vld && !Out_Ready && stall_cnt != {CNT_WIDTH{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;

      if (Flush) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else if (skid_vld) begin
        if (pop) begin
          main_dat <= skid_dat;
          skid_vld <= 1'b0;
        end
      end else if (main_vld) begin
        if (accept && pop) begin
          main_dat <= in_dat;
        end else if (accept) begin
          skid_dat <= in_dat;
          skid_vld <= 1'b1;
        end else if (pop) begin
          main_vld <= 1'b0;
        end
      end else if (accept) begin
        main_dat <= in_dat;
        main_vld <= 1'b1;
      end
    end
  end

  // Side-effecting controls are masked during bubbles; the rest hold their last value
  assign RegWrite_MEM       = main_vld & main_dat.reg_write;
  assign Branch_MEM         = main_vld & main_dat.branch;
  assign MemRead_MEM        = main_vld & main_dat.mem_read;
  assign MemWrite_MEM       = main_vld & main_dat.mem_write;
  assign MemtoReg_MEM       = main_dat.mem_to_reg;
  assign Zero_MEM           = main_dat.zero;
  assign ALU_Result_MEM     = main_dat.alu_result;
  assign Write_Data_MEM     = main_dat.write_data;
  assign Write_Register_MEM = main_dat.write_reg;
  assign Instruction_MEM    = main_dat.instr;
  assign Stall_Count        = stall_cnt;

endmodule

// File: tb/tb_ex_mem_stage_pipe.sv
// Directed bench for ex_mem_stage_pipe with a 4-bit stall counter.
module tb_ex_mem_stage_pipe;
  logic        Clk = 1'b0;
  logic        Reset, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready;
  logic        RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX, Zero_EX;
  logic [31:0] ALU_Result_EX, Read_Data_2_EX, Instruction_EX;
  logic [4:0]  Write_Register_EX;
  logic        RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM, Zero_MEM;
  logic [31:0] ALU_Result_MEM, Write_Data_MEM, Instruction_MEM;
  logic [4:0]  Write_Register_MEM;
  logic [3:0]  Stall_Count;

  int checks = 0;
  int errors = 0;

  ex_mem_stage_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .INSTR_WIDTH(32), .CNT_WIDTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .Branch_EX(Branch_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Zero_EX(Zero_EX),
    .ALU_Result_EX(ALU_Result_EX), .Read_Data_2_EX(Read_Data_2_EX),
    .Write_Register_EX(Write_Register_EX), .Instruction_EX(Instruction_EX),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .Branch_MEM(Branch_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Zero_MEM(Zero_MEM),
    .ALU_Result_MEM(ALU_Result_MEM), .Write_Data_MEM(Write_Data_MEM),
    .Write_Register_MEM(Write_Register_MEM), .Instruction_MEM(Instruction_MEM),
    .Stall_Count(Stall_Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic rw, input logic mw);
    In_Valid          = v;
    ALU_Result_EX     = d;
    Read_Data_2_EX    = ~d;
    Write_Register_EX = d[4:0];
    Instruction_EX    = {16'hC0DE, d[15:0]};
    RegWrite_EX       = rw;
    MemWrite_EX       = mw;
    MemtoReg_EX       = d[0];
    Zero_EX           = d[1];
    Branch_EX         = 1'b0;
    MemRead_EX        = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; Out_Ready = 1'b0;
    beat(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    check("rst_in_ready", In_Ready, 1);
    check("rst_out_valid", Out_Valid, 0);
    check("rst_stall", Stall_Count, 0);
    check("rst_alu", ALU_Result_MEM, 0);
    #9 Reset = 1'b0;
    tick();

    // Single beat
    beat(1'b1, 32'h0000_1234, 1'b1, 1'b0);
    Write_Register_EX = 5'd5;
    Out_Ready = 1'b1;
    tick();
    beat(1'b0, 32'h0, 1'b0, 1'b0);
    check("sb_out_valid", Out_Valid, 1);
    check("sb_alu", ALU_Result_MEM, 32'h1234);
    check("sb_wreg", Write_Register_MEM, 5);
    check("sb_regwrite", RegWrite_MEM, 1);
    check("sb_wdata", Write_Data_MEM, ~32'h1234);
    tick();
    check("sb_bubble_valid", Out_Valid, 0);
    check("sb_bubble_regwrite", RegWrite_MEM, 0);
    check("sb_hold_alu", ALU_Result_MEM, 32'h1234);

    // Back-pressure: A, B, C with MEM stalled
    Out_Ready = 1'b0;
    beat(1'b1, 32'd1, 1'b1, 1'b0);
    tick();
    check("bp_a_ready", In_Ready, 1);
    check("bp_a_valid", Out_Valid, 1);
    beat(1'b1, 32'd2, 1'b1, 1'b0);
    tick();
    check("bp_full_ready", In_Ready, 0);
    beat(1'b1, 32'd3, 1'b1, 1'b0);
    tick();
    check("bp_hold_ready", In_Ready, 0);
    check("bp_hold_alu", ALU_Result_MEM, 1);
    tick();
    check("bp_stall3", Stall_Count, 3);
    Out_Ready = 1'b1;
    check("bp_out_a", ALU_Result_MEM, 1);
    tick();
    check("bp_out_b", ALU_Result_MEM, 2);
    check("bp_b_ready", In_Ready, 1);
    tick();
    check("bp_out_c", ALU_Result_MEM, 3);
    check("bp_c_valid", Out_Valid, 1);
    beat(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("bp_drained", Out_Valid, 0);
    check("bp_stall_final", Stall_Count, 3);

    // Full throughput
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, i, 1'b1, 1'b0);
      tick();
      check("ft_valid", Out_Valid, 1);
      check("ft_data", ALU_Result_MEM, i);
      check("ft_ready", In_Ready, 1);
    end
    beat(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("ft_drained", Out_Valid, 0);
    check("ft_no_stall", Stall_Count, 3);

    // Flush while FULL
    Out_Ready = 1'b0;
    beat(1'b1, 32'hA, 1'b0, 1'b1);
    tick();
    beat(1'b1, 32'hB, 1'b0, 1'b1);
    tick();
    check("fl_full_ready", In_Ready, 0);
    check("fl_memwrite_pre", MemWrite_MEM, 1);
    check("fl_stall_pre", Stall_Count, 4);
    Flush = 1'b1;
    beat(1'b1, 32'hC, 1'b0, 1'b1);
    tick();
    Flush = 1'b0;
    beat(1'b0, 32'h0, 1'b0, 1'b0);
    Out_Ready = 1'b1;
    check("fl_valid", Out_Valid, 0);
    check("fl_memwrite", MemWrite_MEM, 0);
    check("fl_ready", In_Ready, 1);
    check("fl_stall_counted", Stall_Count, 5);
    tick();
    check("fl_no_ghost", Out_Valid, 0);
    tick();
    check("fl_no_ghost2", Out_Valid, 0);

    // Saturation with CNT_WIDTH=4
    Out_Ready = 1'b0;
    beat(1'b1, 32'h55, 1'b0, 1'b0);
    tick();
    beat(1'b0, 32'h0, 1'b0, 1'b0);
    check("sat_start", Stall_Count, 5);
    repeat (9) tick();
    check("sat_14", Stall_Count, 14);
    repeat (11) tick();
    check("sat_15", Stall_Count, 15);
    tick();
    check("sat_hold", Stall_Count, 15);
    check("sat_valid", Out_Valid, 1);

    // Asynchronous reset in FULL
    beat(1'b1, 32'h67, 1'b1, 1'b1);
    tick();
    beat(1'b0, 32'h0, 1'b0, 1'b0);
    check("ar_full", In_Ready, 0);
    check("ar_memtoreg_pre", MemtoReg_MEM, 1);
    #2 Reset = 1'b1;
    #1;
    check("ar_valid", Out_Valid, 0);
    check("ar_ready", In_Ready, 1);
    check("ar_stall", Stall_Count, 0);
    check("ar_alu", ALU_Result_MEM, 0);
    check("ar_wdata", Write_Data_MEM, 0);
    check("ar_wreg", Write_Register_MEM, 0);
    check("ar_instr", Instruction_MEM, 0);
    check("ar_ctrl", {RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM, Zero_MEM}, 0);
    #2 Reset = 1'b0;
    tick();
    check("ar_post_valid", Out_Valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
